// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle MIPS datapath: serves MemRead/MemWrite
// against a word array with WAIT_CYCLES of latency. Optional checks via MEM_RESPONDER_CHECK_EN.
module mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] MemData,
    output logic        MemReady,
    output logic        MemError
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    waitCnt;
    logic                opWrite;
    logic [ADDR_W-1:0]   opIdx;
    logic [DATA_W-1:0]   opData;
    logic                opErr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                reqValid;
    logic                reqWrite;
    logic [ADDR_W-1:0]   reqIdx;
    logic                reqErr;

    assign reqValid = MemRead | MemWrite;
    assign reqWrite = MemWrite;
    assign reqIdx   = Address[ADDR_W+1:2];

`ifdef MEM_RESPONDER_CHECK_EN
    assign reqErr = (Address[1:0] != 2'b00)
                  | (|Address[31:ADDR_W+2])
                  | (MemRead & MemWrite);
`else
    // Low and high address bits are don't-care; the index simply wraps.
    logic unusedAddr;
    assign unusedAddr = ^{Address[31:ADDR_W+2], Address[1:0]};
    assign reqErr     = 1'b0;
`endif

    // The access commits on the edge entering RESP; with zero wait that is the accept edge,
    // so the operands come straight from the request instead of the capture registers.
    logic                fireNow;
    logic                fireWrite;
    logic [ADDR_W-1:0]   fireIdx;
    logic [DATA_W-1:0]   fireData;
    logic                fireErr;

    always_comb begin
        fireNow   = 1'b0;
        fireWrite = opWrite;
        fireIdx   = opIdx;
        fireData  = opData;
        fireErr   = opErr;
        case (state)
            IDLE: begin
                if (NO_WAIT && reqValid) begin
                    fireNow   = 1'b1;
                    fireWrite = reqWrite;
                    fireIdx   = reqIdx;
                    fireData  = WriteData;
                    fireErr   = reqErr;
                end
            end
            WAIT:    fireNow = (waitCnt == CNT_W'(1));
            default: fireNow = 1'b0;
        endcase
    end

    // Control FSM, registered outputs and array port; the array itself is never reset,
    // but reset blocks any commit so an interrupted write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            opWrite  <= 1'b0;
            opIdx    <= '0;
            opData   <= '0;
            opErr    <= 1'b0;
            MemData  <= '0;
            MemReady <= 1'b0;
            MemError <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            MemError <= 1'b0;

            if (fireNow) begin
                MemReady <= 1'b1;
                MemError <= fireErr;
                if (!fireErr) begin
                    if (fireWrite) begin
                        mem[fireIdx] <= fireData;
                    end else begin
                        MemData <= mem[fireIdx];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (reqValid) begin
                        opWrite <= reqWrite;
                        opIdx   <= reqIdx;
                        opData  <= WriteData;
                        opErr   <= reqErr;
                        waitCnt <= WAIT_INIT;
                        state   <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - CNT_W'(1);
                    if (waitCnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed test-plan steps plus randomized accesses
// checked against a word-array reference model; one WAIT_CYCLES=2 and one WAIT_CYCLES=0 instance.
module tb_mem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned WC    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] Address, WriteData;
    logic [31:0] MemData;
    logic        MemReady, MemError;

    logic        rst0;
    logic        rd0, wr0;
    logic [31:0] addr0, wdata0;
    logic [31:0] data0;
    logic        ready0, err0;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] expData;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData),
        .MemData(MemData), .MemReady(MemReady), .MemError(MemError)
    );

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0),
        .MemRead(rd0), .MemWrite(wr0),
        .Address(addr0), .WriteData(wdata0),
        .MemData(data0), .MemReady(ready0), .MemError(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit expErr(input bit rd, input bit wr, input logic [31:0] addr);
`ifdef MEM_RESPONDER_CHECK_EN
        return (addr % 4 != 0) || ((addr >> (AW + 2)) != 0) || (rd && wr);
`else
        return 1'b0;
`endif
    endfunction

    // One complete access on the WAIT_CYCLES=2 instance, starting at a negedge in IDLE.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit mutate, input string tag);
        bit          err;
        int unsigned idx;
        err = expErr(rd, wr, addr);
        idx = (addr / 4) % DEPTH;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wdata;
        for (int c = 1; c <= int'(WC) + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1 && mutate) begin
                Address   = addr ^ 32'h4;
                WriteData = ~wdata;
            end
            if (c <= int'(WC)) begin
                check({tag, "_ready_wait"}, 32'(MemReady), 32'd0);
                check({tag, "_data_wait"}, MemData, expData);
            end
        end
        if (!err) begin
            if (wr) model[idx] = wdata;
            else    expData    = model[idx];
        end
        check({tag, "_ready"}, 32'(MemReady), 32'd1);
        check({tag, "_error"}, 32'(MemError), 32'(err));
        check({tag, "_data"}, MemData, expData);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(MemReady), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        bit          rd, wr;
        int unsigned k, kind;

        rst = 1'b1; rst0 = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        expData = '0;
        repeat (2) @(negedge clk);
        check("reset_data", MemData, 32'd0);
        check("reset_ready", 32'(MemReady), 32'd0);
        check("reset_error", 32'(MemError), 32'd0);
        check("reset0_data", data0, 32'd0);
        rst = 1'b0; rst0 = 1'b0;
        @(negedge clk);

        // Basic write then read
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd10");

        // Inputs changed after acceptance must be ignored
        access(1'b0, 1'b1, 32'h24, 32'h5A5A5A5A, 1'b0, "wr24");
        access(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1, "wr20_mut");
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rd20");
        access(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, "rd24");

        // Misaligned read, out-of-range write aliasing onto word 0
        access(1'b1, 1'b0, 32'h22, 32'h0, 1'b0, "rd22");
        access(1'b0, 1'b1, 32'h0, 32'h01234567, 1'b0, "wr0");
        access(1'b0, 1'b1, 32'h1000, 32'h89ABCDEF, 1'b0, "wr1000");
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "rd0");

        // Reset during WAIT of a write: outputs clear at once, write never lands
        access(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, "wr40");
        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "rd40a");
        MemWrite = 1'b1; Address = 32'h40; WriteData = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_data", MemData, 32'd0);
        check("rstmid_ready", 32'(MemReady), 32'd0);
        check("rstmid_error", 32'(MemError), 32'd0);
        expData  = '0;
        MemWrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_ready_after", 32'(MemReady), 32'd0);
        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "rd40b");

        // Simultaneous read and write
        access(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 1'b0, "wr30");
        access(1'b1, 1'b1, 32'h30, 32'hFEEDFACE, 1'b0, "rdwr30");
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "rd30");

        // Zero-wait instance: ready one cycle after request; held request is a second access
        wr0 = 1'b1; addr0 = 32'h80; wdata0 = 32'hA5A50F0F;
        @(posedge clk); @(negedge clk);
        check("z_wr_ready", 32'(ready0), 32'd1);
        check("z_wr_error", 32'(err0), 32'd0);
        wr0 = 1'b0;
        @(negedge clk);
        rd0 = 1'b1;
        @(posedge clk); @(negedge clk);
        check("z_rd1_ready", 32'(ready0), 32'd1);
        check("z_rd1_data", data0, 32'hA5A50F0F);
        @(posedge clk); @(negedge clk);
        check("z_gap_ready", 32'(ready0), 32'd0);
        @(posedge clk); @(negedge clk);
        check("z_rd2_ready", 32'(ready0), 32'd1);
        check("z_rd2_data", data0, 32'hA5A50F0F);
        rd0 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("z_idle_ready", 32'(ready0), 32'd0);

        // Randomized traffic over a small window of words
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            k    = $urandom_range(15, 0);
            kind = $urandom_range(9, 0);
            a    = 32'h100 + 32'(4 * k);
            rd   = $urandom_range(1, 0) == 1;
            wr   = !rd;
            if (kind == 0) a = a + 32'($urandom_range(3, 1));
            if (kind == 1) a = a | 32'h0001_0000;
            if (kind == 2) begin rd = 1'b1; wr = 1'b1; end
            access(rd, wr, a, $urandom, kind == 3, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
